// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared encodings for the CPU run/step/breakpoint controller.
// Holds controller state codes, host command codes and stop-reason codes.
package cpu_run_ctrl_pkg;

   localparam int PC_W = 32;

   typedef enum logic [1:0] {
      ST_PAUSED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } run_state_e;

   typedef enum logic [2:0] {
      CMD_NOP      = 3'd0,
      CMD_RUN      = 3'd1,
      CMD_PAUSE    = 3'd2,
      CMD_STEP     = 3'd3,
      CMD_SET_BP   = 3'd4,
      CMD_CLR_BP   = 3'd5,
      CMD_CLR_CNT  = 3'd6,
      CMD_CLR_HALT = 3'd7
   } cmd_op_e;

   typedef enum logic [1:0] {
      RSN_USER  = 2'd0,
      RSN_STEP  = 2'd1,
      RSN_BP    = 2'd2,
      RSN_HALT  = 2'd3
   } stop_reason_e;

   // True when the controller lets the CPU advance (RUN or STEP).
   function automatic logic is_active(input run_state_e st);
      logic act;
      case (st)
         ST_RUN:  act = 1'b1;
         ST_STEP: act = 1'b1;
         default: act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/run_ctrl_counter.sv
// run_ctrl_counter: CNT_W-wide wrapping counter with synchronous clear
// (clear beats increment) and increment enable. Async active-high reset.
module run_ctrl_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, otherwise increment with natural wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = ZERO;
      end else if (inc) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller driving the CPU global_en.
// Observes the CPU commit port, stops on halt instruction, PC breakpoint,
// end of a single step or a host PAUSE, and keeps cycle/instruction counters.
// Optional feature macro: CPU_RUN_CTRL_BP_EN (PC breakpoint register and
// comparator). Without it, SET_BP/CLR_BP are accepted but do nothing.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [31:0]      cmd_arg,
   input  logic             commit,
   input  logic [31:0]      commit_pc,
   input  logic             commit_halt,
   output logic             global_en,
   output logic [1:0]       state,
   output logic [1:0]       stop_reason,
   output logic             stop_pulse,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] inst_cnt
);

   run_state_e   state_q, state_d;
   stop_reason_e reason_q, reason_d;
   logic         pulse_q, pulse_d;
   logic         prev_en_q, prev_en_d;

   logic cmd_fire;
   logic new_commit;
   logic bp_hit;
   logic stop_now;
   logic cnt_clr;

   assign cmd_ready  = (state_q != ST_STEP);
   assign cmd_fire   = cmd_valid && cmd_ready;
   // Commit data is only fresh if the CPU advanced in the previous cycle;
   // a frozen CPU keeps presenting its last commit and must not recount it.
   assign new_commit = commit && prev_en_q;
   assign stop_now   = new_commit && (commit_halt || bp_hit || (state_q == ST_STEP));
   // Combinational so the stopping instruction is the last one the CPU commits.
   assign global_en  = is_active(state_q) && !stop_now;
   assign cnt_clr    = cmd_fire && (cmd_op == CMD_CLR_CNT);

`ifdef CPU_RUN_CTRL_BP_EN
   logic [PC_W-1:0] bp_pc_q, bp_pc_d;
   logic            bp_valid_q, bp_valid_d;

   // Breakpoint register update from SET_BP / CLR_BP.
   always_comb begin
      bp_pc_d    = bp_pc_q;
      bp_valid_d = bp_valid_q;
      if (cmd_fire && (cmd_op == CMD_SET_BP)) begin
         bp_pc_d    = cmd_arg;
         bp_valid_d = 1'b1;
      end else if (cmd_fire && (cmd_op == CMD_CLR_BP)) begin
         bp_valid_d = 1'b0;
      end else begin
         bp_valid_d = bp_valid_q;
      end
   end

   // Breakpoint storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bp_pc_q    <= {PC_W{1'b0}};
         bp_valid_q <= 1'b0;
      end else begin
         bp_pc_q    <= bp_pc_d;
         bp_valid_q <= bp_valid_d;
      end
   end

   assign bp_hit = new_commit && bp_valid_q && (commit_pc == bp_pc_q);
`else
   logic unused_bp_inputs;
   assign unused_bp_inputs = &{1'b0, cmd_arg, commit_pc};
   assign bp_hit = 1'b0;
`endif

   // Next-state logic: halt beats breakpoint beats host command.
   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      case (state_q)
         ST_PAUSED: begin
            if (cmd_fire && (cmd_op == CMD_RUN)) begin
               state_d = ST_RUN;
            end else if (cmd_fire && (cmd_op == CMD_STEP)) begin
               state_d = ST_STEP;
            end else begin
               state_d = ST_PAUSED;
            end
         end
         ST_RUN: begin
            if (new_commit && commit_halt) begin
               state_d  = ST_HALTED;
               reason_d = RSN_HALT;
            end else if (bp_hit) begin
               state_d  = ST_PAUSED;
               reason_d = RSN_BP;
            end else if (cmd_fire && (cmd_op == CMD_PAUSE)) begin
               state_d  = ST_PAUSED;
               reason_d = RSN_USER;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_STEP: begin
            // A step ends on its commit even if the breakpoint also matches.
            if (new_commit && commit_halt) begin
               state_d  = ST_HALTED;
               reason_d = RSN_HALT;
            end else if (new_commit) begin
               state_d  = ST_PAUSED;
               reason_d = RSN_STEP;
            end else begin
               state_d = ST_STEP;
            end
         end
         ST_HALTED: begin
            // Leaving HALTED keeps the halt reason visible.
            if (cmd_fire && (cmd_op == CMD_CLR_HALT)) begin
               state_d = ST_PAUSED;
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: begin
            state_d  = ST_PAUSED;
            reason_d = RSN_USER;
         end
      endcase
   end

   // Stop pulse marks any active-to-stopped transition; remember this cycle's enable.
   always_comb begin
      pulse_d   = is_active(state_q) && !is_active(state_d);
      prev_en_d = global_en;
   end

   // Controller state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PAUSED;
         reason_q  <= RSN_USER;
         pulse_q   <= 1'b0;
         prev_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         reason_q  <= reason_d;
         pulse_q   <= pulse_d;
         prev_en_q <= prev_en_d;
      end
   end

   assign state       = state_q;
   assign stop_reason = reason_q;
   assign stop_pulse  = pulse_q;

   run_ctrl_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (global_en),
      .cnt (cycle_cnt)
   );

   run_ctrl_counter #(.CNT_W(CNT_W)) u_inst_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (new_commit),
      .cnt (inst_cnt)
   );

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller that sequences the pipelined CPU core by driving its `global_en` input. It sits between the debug host and the CPU top and observes the CPU commit port. It implements free-run, single-instruction step, a PC breakpoint and halt-instruction detection. It also keeps 32-bit cycle and retired-instruction counters.

## Interface
Parameters:
- `CNT_W`, 32: width of `cycle_cnt` / `inst_cnt`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  controller accepts a command. A command is taken on a rising edge with `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  command code:
  - 0 NOP, 1 RUN, 2 PAUSE, 3 STEP
  - 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 CLR_HALT
- `cmd_arg`  in  32  breakpoint PC for SET_BP. Ignored for all other commands.
- `commit`  in  1  CPU commit valid. Registered in the CPU.
- `commit_pc`  in  32  PC of the committing instruction.
- `commit_halt`  in  1  committing instruction is the halt instruction.
- `global_en`  out  1  CPU advance enable.
- `state`  out  2  0 PAUSED, 1 RUN, 2 STEP, 3 HALTED.
- `stop_reason`  out  2  0 user pause, 1 step done, 2 breakpoint, 3 halt.
- `stop_pulse`  out  1  one-cycle pulse after any entry into PAUSED or HALTED from RUN or STEP.
- `cycle_cnt`  out  CNT_W  enabled-cycle counter.
- `inst_cnt`  out  CNT_W  retired-instruction counter.

## Operation
- `en_d`: register holding the previous cycle's `global_en`.
- `new_commit = commit && en_d`. Stale commit data held while the CPU is frozen is never counted twice.
- `bp_hit = new_commit && bp_valid && commit_pc == bp_pc`.
- `stop_now = new_commit && (commit_halt || bp_hit || state == STEP)`.
- `global_en = (state == RUN || state == STEP) && !stop_now`. This is combinational, so the CPU freezes with the stopping instruction as the last commit and executes no extra cycle.

State transitions (registered):
- PAUSED:
  - RUN → RUN.
  - STEP → STEP.
  - PAUSE is a no-op.
- RUN:
  - `new_commit && commit_halt` → HALTED, reason 3.
  - else `bp_hit` → PAUSED, reason 2.
  - else accepted PAUSE → PAUSED, reason 0.
- STEP:
  - `new_commit && commit_halt` → HALTED, reason 3.
  - else `new_commit` → PAUSED, reason 1. The step ends even if the breakpoint also matches.
- HALTED:
  - CLR_HALT → PAUSED; `stop_reason` is unchanged.
  - RUN, STEP and PAUSE are accepted and have no effect.

Command handling:
- `cmd_ready = (state != STEP)`.
- SET_BP, CLR_BP and CLR_CNT are legal in every state that accepts commands.
- SET_BP: `bp_pc <= cmd_arg`, `bp_valid <= 1`.
- CLR_BP: `bp_valid <= 0`.
- Priority within one cycle: halt > breakpoint > command.

Counters:
- `cycle_cnt` increments on every edge with `global_en == 1`.
- `inst_cnt` increments on every `new_commit`, including the stopping commit.
- Both counters wrap modulo 2^CNT_W.
- CLR_CNT in the same cycle as an increment: the clear wins and the counter becomes 0.

## Timing
- Reset values:
  - `state` = PAUSED, `stop_reason` = 0, `stop_pulse` = 0
  - `global_en` = 0, `en_d` = 0
  - `cycle_cnt` = 0, `inst_cnt` = 0
  - `bp_valid` = 0, `bp_pc` = 0
  - `cmd_ready` = 1
- Reset asserted mid-RUN forces all of the above asynchronously.
- RUN or STEP accepted at edge N: `global_en` = 1 from cycle N+1.
- PAUSE accepted at edge N: `global_en` = 0 from cycle N+1, i.e. one cycle later than a breakpoint or halt stop.
- `stop_pulse` is high for exactly the cycle after the state-changing edge.
- Resume after a breakpoint: in the first enabled cycle `en_d` = 0, so the held breakpoint commit does not re-trigger.

## Configuration
- `CPU_RUN_CTRL_BP_EN` defined:
  - breakpoint registers and comparator present, as described above.
- `CPU_RUN_CTRL_BP_EN` undefined:
  - no `bp_pc` / `bp_valid` storage; `bp_hit` is constant 0.
  - SET_BP and CLR_BP are accepted as no-ops.
  - `stop_reason` never takes value 2.

## Structure
- Package `cpu_run_ctrl_pkg` holds:
  - state encodings (PAUSED/RUN/STEP/HALTED)
  - `cmd_op` codes 0–7
  - `stop_reason` codes.
- Sub-module `run_ctrl_counter`:
  - CNT_W-wide counter with synchronous clear (priority over increment) and increment enable.
  - Instantiated twice, once per counter.
- The FSM and breakpoint compare live in the top module.

## Test plan
- Reset, then RUN with a CPU model committing every cycle for 10 cycles, then PAUSE:
  - `cycle_cnt` = 10, `inst_cnt` = 10, `stop_reason` = 0
  - `stop_pulse` high for one cycle.
- SET_BP `cmd_arg` = 0x1C, then RUN:
  - freeze in the same cycle that `commit_pc` = 0x1C, with `global_en` = 0 in that cycle
  - `stop_reason` = 2
  - RUN again: no re-trigger at 0x1C; execution continues to 0x20.
- STEP with commits arriving after 3 bubble cycles:
  - `cmd_ready` = 0 during the step
  - exactly one `inst_cnt` increment
  - return to PAUSED, `stop_reason` = 1.
- Commit with `commit_halt` = 1 during RUN while a breakpoint on the same PC is armed:
  - HALTED, `stop_reason` = 3
  - RUN ignored; CLR_HALT → PAUSED.
- CLR_CNT in the same cycle as a commit: both counters read 0 the next cycle.
- Assert `rst` mid-RUN: all outputs take their reset values immediately, without waiting for a clock edge.
